blockmem_responder: RTL and testbench

Memory-side responder for the data cache's block-transfer port. Accepts one block refill (read) or dirty-block writeback (write) request at a time over a valid/ready handshake, services it from a local block-organized backing store after a fixed programmable latency, and returns the read block or a write acknowledgement over a valid/ready response channel. It sits between the cache controller and the backing memory model, and replaces the zero-latency combinational memory access path.

---
 rtl/blockmem_responder_pkg.sv | 26 ++
 rtl/blockmem_responder_array.sv | 42 ++++
 rtl/blockmem_responder.sv | 130 +++++++++++++
 tb/tb_blockmem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blockmem_responder_pkg.sv
// ----------------------------------------------------------------------------
// blockmem_responder_pkg
//   Constants and types shared by the block-memory responder and the data
//   cache it serves.
//   - BLOCK_SIZE / WORD_SIZE / CACHE_OFFSET_LEN : cache geometry constants
//   - blk_state_t                               : responder FSM states
//   - REQ_* / RESP_* widths                     : request/response field widths
// ----------------------------------------------------------------------------
package blockmem_responder_pkg;

    localparam int unsigned BLOCK_SIZE       = 256;
    localparam int unsigned WORD_SIZE        = 32;
    localparam int unsigned CACHE_OFFSET_LEN = 5;

    // Request/response field widths
    localparam int unsigned REQ_ADDR_W  = WORD_SIZE;
    localparam int unsigned REQ_WDATA_W = BLOCK_SIZE;
    localparam int unsigned RESP_DATA_W = BLOCK_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } blk_state_t;

endpackage

// File: rtl/blockmem_responder_array.sv
// ----------------------------------------------------------------------------
// blockmem_array
//   Single-port block storage, DEPTH entries of WIDTH bits. Write and read are
//   both synchronous; the read result lands in a dedicated output register that
//   only changes when i_re is asserted. No reset: contents start at zero in
//   simulation and are never cleared afterwards.
//   Ports:
//     clk      in   clock
//     i_we     in   write enable (stores i_wdata at i_idx)
//     i_re     in   read enable (loads o_rdata from i_idx)
//     i_idx    in   block index
//     i_wdata  in   write block
//     o_rdata  out  registered read block
// ----------------------------------------------------------------------------
module blockmem_array #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 256,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/blockmem_responder.sv
// ----------------------------------------------------------------------------
// blockmem_responder
//   Memory-side responder for the data cache block-transfer port. Accepts one
//   refill/writeback at a time, services it from blockmem_array after LATENCY
//   cycles, and presents the result until the cache takes it.
//   Ports:
//     clk, rst_n               clock, async active-low reset
//     req_valid / req_ready    request handshake (ready only when idle)
//     req_write                1 = writeback, 0 = refill
//     req_addr                 byte address; offset and bits above index unused
//     req_wdata                writeback block
//     resp_valid / resp_ready  response handshake
//     resp_write               echo of the accepted req_write
//     resp_rdata               read block, zero for writeback responses
// ----------------------------------------------------------------------------
module blockmem_responder #(
    parameter int unsigned BLOCK_SIZE = blockmem_responder_pkg::BLOCK_SIZE,
    parameter int unsigned WORD_SIZE  = blockmem_responder_pkg::WORD_SIZE,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [WORD_SIZE-1:0]  req_addr,
    input  logic [BLOCK_SIZE-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_write,
    output logic [BLOCK_SIZE-1:0] resp_rdata
);
    import blockmem_responder_pkg::*;

    localparam int unsigned OFF_W = CACHE_OFFSET_LEN;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    blk_state_t            r_state;
    blk_state_t            w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_write;
    logic                  r_rdata_vld;
    logic [IDX_W-1:0]      r_idx;
    logic [BLOCK_SIZE-1:0] r_wdata;
    logic                  w_accept;
    logic                  w_commit;
    logic [BLOCK_SIZE-1:0] w_arr_rdata;
    logic                  w_unused_addr;

    assign w_unused_addr = ^{req_addr[WORD_SIZE-1:OFF_W+IDX_W], req_addr[OFF_W-1:0]};

    assign w_accept = req_valid && req_ready;
    assign w_commit = (r_state == BUSY) && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (r_cnt == '0) w_state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_rdata_vld stands in for a reset on the array's read register: the
    // response bus shows zero after reset and after a write commits, and the
    // array output otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_rdata_vld <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= CNT_LOAD;
                r_write <= req_write;
            end else if ((r_state == BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_commit) begin
                r_rdata_vld <= ~r_write;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx   <= req_addr[OFF_W +: IDX_W];
            r_wdata <= req_wdata;
        end
    end

    blockmem_array #(
        .DEPTH (DEPTH),
        .WIDTH (BLOCK_SIZE),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_commit && r_write),
        .i_re    (w_commit && !r_write),
        .i_idx   (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

    assign resp_write = r_write;
    assign resp_rdata = r_rdata_vld ? w_arr_rdata : '0;

endmodule

// File: tb/tb_blockmem_responder.sv
// ----------------------------------------------------------------------------
// tb_blockmem_responder
//   Two responders (LATENCY=4 and LATENCY=1) share the bench request signals;
//   'sel' routes handshakes to one of them and picks which outputs are seen.
//   A per-instance array of blocks models the backing store.
// ----------------------------------------------------------------------------
module tb_blockmem_responder;

    localparam int unsigned DEPTH = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sel;
    logic         req_valid, req_write, resp_ready;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata;

    logic         rr0, rv0, rw0, rr1, rv1, rw1;
    logic [255:0] rd0, rd1;

    logic         req_ready, resp_valid, resp_write;
    logic [255:0] resp_rdata;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [255:0] ref_mem [2][DEPTH];

    always #5 clk = ~clk;

    blockmem_responder #(.BLOCK_SIZE(256), .WORD_SIZE(32), .DEPTH(DEPTH), .LATENCY(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && !sel), .req_ready(rr0), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_ready(resp_ready && !sel),
        .resp_write(rw0), .resp_rdata(rd0)
    );

    blockmem_responder #(.BLOCK_SIZE(256), .WORD_SIZE(32), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && sel), .req_ready(rr1), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_ready(resp_ready && sel),
        .resp_write(rw1), .resp_rdata(rd1)
    );

    assign req_ready  = sel ? rr1 : rr0;
    assign resp_valid = sel ? rv1 : rv0;
    assign resp_write = sel ? rw1 : rw0;
    assign resp_rdata = sel ? rd1 : rd0;

    function automatic int blk(input logic [31:0] addr);
        return int'((addr / 32) % DEPTH);
    endfunction

    function automatic logic [255:0] rand_block();
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // One full transaction: accept, latency, optional stall, handshake.
    // 'inject' pulses a conflicting write while the responder is busy.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                       input int stall, input bit inject, input string name);
        int n;
        int lat;
        logic [255:0] exp;
        lat = sel ? 1 : 4;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data;
        resp_ready = (stall == 0);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        n_vec++;
        if (!req_ready) begin
            n_err++;
            $display("FAIL %s_accept_timeout: req_ready=%b required 1", name, req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = inject && !sel;
        req_write = 1'b1; req_addr = addr ^ 32'h0000_0120; req_wdata = rand_block();
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            req_valid = 1'b0;
            n++;
        end
        req_valid = 1'b0;
        n_vec++;
        if (n !== lat) begin
            n_err++;
            $display("FAIL %s_latency: got %0d cycles required %0d", name, n, lat);
        end
        exp = wr ? 256'd0 : ref_mem[sel][blk(addr)];
        if (wr) ref_mem[sel][blk(addr)] = data;
        n_vec++;
        if (resp_write !== wr) begin
            n_err++;
            $display("FAIL %s_resp_write: got %b required %b", name, resp_write, wr);
        end
        n_vec++;
        if (resp_rdata !== exp) begin
            n_err++;
            $display("FAIL %s_rdata: got %h required %h", name, resp_rdata, exp);
        end
        n_vec++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s_ready_in_resp: got %b required 0", name, req_ready);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            n_vec++;
            if (resp_valid !== 1'b1 || resp_rdata !== exp || req_ready !== 1'b0
                || resp_write !== wr) begin
                n_err++;
                $display("FAIL %s_stall%0d: valid=%b ready=%b rdata=%h required 1/0/%h",
                         name, i, resp_valid, req_ready, resp_rdata, exp);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_handshake: valid=%b ready=%b required 0/1",
                     name, resp_valid, req_ready);
        end
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({rr0, rv0, rw0, rr1, rv1, rw1} !== 6'b100_100) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 100100", {rr0, rv0, rw0, rr1, rv1, rw1});
        end
        n_vec++;
        if (rd0 !== 256'd0 || rd1 !== 256'd0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h / %h required 0", rd0, rd1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        sel = 1'b0;
        txn(1'b1, 32'h40, {32{8'hA5}}, 0, 1'b0, "wr_a5");
        txn(1'b0, 32'h40, '0, 0, 1'b0, "rd_a5");
    endtask

    task automatic test_offset_alias();
        sel = 1'b0;
        txn(1'b0, 32'h5F, '0, 0, 1'b0, "rd_offset");
        txn(1'b1, 32'h800, rand_block(), 0, 1'b0, "wr_alias");
        txn(1'b0, 32'h000, '0, 0, 1'b0, "rd_alias");
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        txn(1'b0, 32'h40, '0, 10, 1'b0, "bp_read");
        txn(1'b1, 32'h1E0, rand_block(), 10, 1'b0, "bp_write");
    endtask

    task automatic test_busy_reject();
        sel = 1'b0;
        txn(1'b0, 32'h40, '0, 0, 1'b1, "busy_rd");
        // Injected write targeted 0x40 ^ 0x120 = 0x160; it must not have landed.
        txn(1'b0, 32'h160, '0, 0, 1'b0, "busy_victim");
        txn(1'b1, 32'h260, rand_block(), 1, 1'b1, "busy_wr");
        txn(1'b0, 32'h340, '0, 0, 1'b0, "busy_victim2");
    endtask

    task automatic test_reset_mid_write();
        logic [255:0] pat_b;
        sel = 1'b0;
        pat_b = rand_block();
        txn(1'b1, 32'h80, rand_block(), 0, 1'b0, "rmw_wr_a");
        txn(1'b0, 32'h80, '0, 0, 1'b0, "rmw_rd_a");
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_wdata = pat_b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_write !== 1'b0) begin
            n_err++;
            $display("FAIL rmw_reset_ctrl: ready=%b valid=%b write=%b required 1/0/0",
                     req_ready, resp_valid, resp_write);
        end
        n_vec++;
        if (resp_rdata !== 256'd0) begin
            n_err++;
            $display("FAIL rmw_reset_rdata: got %h required 0", resp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        txn(1'b0, 32'h80, '0, 0, 1'b0, "rmw_rd_after");
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 36; i++) begin
            sel = (i >= 24);
            a = (($urandom & 32'hFF)) | (32'($urandom_range(0, 3)) << 11);
            txn(1'($urandom_range(0, 1)), a, rand_block(), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), "rand");
        end
    endtask

    task automatic test_latency1();
        int acc;
        logic [255:0] d;
        sel = 1'b1;
        d = rand_block();
        txn(1'b1, 32'hC0, d, 0, 1'b0, "l1_wr");
        txn(1'b0, 32'hC0, '0, 0, 1'b0, "l1_rd");
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hC0; resp_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            if (req_ready) acc++;
            @(negedge clk);
        end
        req_valid = 1'b0; resp_ready = 1'b0;
        n_vec++;
        if (acc !== 10) begin
            n_err++;
            $display("FAIL l1_throughput: got %0d accepts in 30 cycles required 10", acc);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++) ref_mem[s][i] = '0;
        sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0;
        req_addr = '0; req_wdata = '0;
        test_reset();
        test_write_read();
        test_offset_alias();
        test_backpressure();
        test_busy_reject();
        test_reset_mid_write();
        test_random();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

endmodule
